// File: rtl/dpr_arb_pkg.sv
// dpr_arb_pkg: shared defaults, port-select encoding and read-tag type for the dual-port RAM arbiter
package dpr_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_SIZE_DEF = 8;
  localparam int IDX_W = 3;
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;
  typedef struct packed {
    logic             valid;
    port_sel_t        port;
    logic [IDX_W-1:0] index;
  } rd_tag_t;
endpackage

// File: rtl/dpr_port_arbiter_if.sv
// dpr_port_arbiter_if: requester-side request/grant/read-return bundle of the arbiter
interface dpr_port_arbiter_if #(
  parameter int NUM_REQ = dpr_arb_pkg::NUM_REQ_DEF,
  parameter int ADDR_SIZE = dpr_arb_pkg::ADDR_SIZE_DEF,
  parameter int DATA_SIZE = dpr_arb_pkg::DATA_SIZE_DEF
) ();
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           we;
  logic [NUM_REQ*ADDR_SIZE-1:0] addr;
  logic [NUM_REQ*DATA_SIZE-1:0] wdata;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           rvalid;
  logic [NUM_REQ*DATA_SIZE-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dpr_port_arbiter_rr_pick.sv
// rr_pick: circular find-first-set, returns the lowest set index at or after start
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  always_comb begin
    rot = N'({req, req} >> start);
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = W'(k);
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
    found = |req;
  end
endmodule

// File: rtl/dpr_port_arbiter.sv
// dpr_port_arbiter: round-robin arbiter mapping up to two requesters per cycle onto a dual-port RAM
module dpr_port_arbiter
  import dpr_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  dpr_port_arbiter_if.slave    bus,
  output logic                 en_a,
  output logic                 we_a,
  output logic [ADDR_SIZE-1:0] addr_a,
  output logic [DATA_SIZE-1:0] din_a,
  output logic                 en_b,
  output logic                 we_b,
  output logic [ADDR_SIZE-1:0] addr_b,
  output logic [DATA_SIZE-1:0] din_b,
  input  logic [DATA_SIZE-1:0] dout_a,
  input  logic [DATA_SIZE-1:0] dout_b,
  output logic [15:0]          conflict_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0]        rr_ptr, idx_a, idx_b, nxt_a, last;
  logic                 found_a, found_b, conflict;
  logic [NUM_REQ-1:0]   req_b;
  logic [ADDR_SIZE-1:0] addr_v [NUM_REQ];
  logic [DATA_SIZE-1:0] wdata_v [NUM_REQ];
  rd_tag_t              tag_a, tag_b;
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
  endfunction
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_v[g] = bus.addr[g*ADDR_SIZE +: ADDR_SIZE];
    assign wdata_v[g] = bus.wdata[g*DATA_SIZE +: DATA_SIZE];
  end
  rr_pick #(.N(NUM_REQ)) u_pick_a (.req(bus.req), .start(rr_ptr), .found(found_a), .idx(idx_a));
  assign nxt_a = wrap_inc(idx_a);
  // the second search starts just past the first winner with that winner removed
  assign req_b = bus.req & ~(NUM_REQ'(1) << idx_a);
  rr_pick #(.N(NUM_REQ)) u_pick_b (.req(req_b), .start(nxt_a), .found(found_b), .idx(idx_b));
  always_comb begin
    conflict = reset && found_b && addr_v[idx_b] == addr_v[idx_a] && (bus.we[idx_a] || bus.we[idx_b]);
    en_a = reset && found_a;
    we_a = en_a && bus.we[idx_a];
    addr_a = en_a ? addr_v[idx_a] : '0;
    din_a = en_a ? wdata_v[idx_a] : '0;
    en_b = reset && found_b && !conflict;
    we_b = en_b && bus.we[idx_b];
    addr_b = en_b ? addr_v[idx_b] : '0;
    din_b = en_b ? wdata_v[idx_b] : '0;
    bus.gnt = (NUM_REQ'(en_a) << idx_a) | (NUM_REQ'(en_b) << idx_b);
    last = en_b ? idx_b : idx_a;
  end
  // read data lands one cycle after the grant; the tag remembers which port and requester own it
  always_comb begin
    bus.rvalid = '0;
    bus.rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_a.valid && tag_a.index == IDX_W'(i)) begin
        bus.rvalid[i] = 1'b1;
        bus.rdata[i*DATA_SIZE +: DATA_SIZE] = (tag_a.port == PORT_B) ? dout_b : dout_a;
      end
      if (tag_b.valid && tag_b.index == IDX_W'(i)) begin
        bus.rvalid[i] = 1'b1;
        bus.rdata[i*DATA_SIZE +: DATA_SIZE] = (tag_b.port == PORT_B) ? dout_b : dout_a;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rr_ptr <= '0;
      tag_a <= '0;
      tag_b <= '0;
      conflict_cnt <= '0;
    end else begin
      if (en_a) rr_ptr <= wrap_inc(last);
      tag_a <= '{valid: en_a && !we_a, port: PORT_A, index: IDX_W'(idx_a)};
      tag_b <= '{valid: en_b && !we_b, port: PORT_B, index: IDX_W'(idx_b)};
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
endmodule

// File: tb/tb_dpr_port_arbiter.sv
// tb_dpr_port_arbiter: directed scenarios with a read-return scoreboard against a reference memory
module tb_dpr_port_arbiter;
  localparam logic [31:0] BASE = 32'h40302010;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  dpr_port_arbiter_if #(.NUM_REQ(4), .ADDR_SIZE(8), .DATA_SIZE(8)) bus ();
  logic       en_a, we_a, en_b, we_b;
  logic [7:0] addr_a, din_a, addr_b, din_b, dout_a, dout_b;
  logic [15:0] conflict_cnt;
  dpr_port_arbiter #(.NUM_REQ(4), .ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a), .dout_b(dout_b), .conflict_cnt(conflict_cnt)
  );
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  always @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= din_a;
      dout_a <= mem[addr_a];
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= din_b;
      dout_b <= mem[addr_b];
    end
  end
  typedef struct packed {
    logic [3:0]  rv;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req = r;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
    #1;
  endtask
  task automatic settle(input logic [3:0] eg);
    exp_t e;
    e = '0;
    check("gnt", bus.gnt, eg);
    for (int i = 0; i < 4; i++)
      if (eg[i]) begin
        if (bus.we[i]) ref_mem[bus.addr[i*8 +: 8]] = bus.wdata[i*8 +: 8];
        else begin
          e.rv[i] = 1'b1;
          e.rd[i*8 +: 8] = ref_mem[bus.addr[i*8 +: 8]];
        end
      end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("rvalid", bus.rvalid, e.rv);
    check("rdata", bus.rdata, e.rd);
  endtask
  task automatic cyc(input logic [3:0] r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] eg);
    drive(r, w, a, d);
    settle(eg);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_gnt"}, bus.gnt, 0);
    check({tag, "_rvalid"}, bus.rvalid, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_en"}, {en_a, en_b, we_a, we_b}, 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    bus.req = 4'hF;
    bus.we = 4'h0;
    bus.addr = BASE;
    bus.wdata = '0;
    @(negedge clk);
    check_idle("reset");
    check("reset_cnt", conflict_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(4'hF, 4'h0, BASE, 0);
    check("first_addr_a", addr_a, 8'h10);
    check("first_addr_b", addr_b, 8'h20);
    settle(4'b0011);
    cyc(4'b1100, 4'h0, BASE, 0, 4'b1100);
    drive(4'b1000, 4'h0, BASE, 0);
    check("only3_port_a", {en_a, addr_a}, {1'b1, 8'h40});
    check("only3_port_b", {en_b, addr_b}, 0);
    settle(4'b1000);
    drive(4'b0011, 4'h0, BASE, 0);
    check("pair_port_a", {en_a, we_a, addr_a}, {2'b10, 8'h10});
    check("pair_port_b", {en_b, we_b, addr_b}, {2'b10, 8'h20});
    settle(4'b0011);
    cyc(4'b1100, 4'h0, BASE, 0, 4'b1100);
    drive(4'b0101, 4'b0101, 32'h33333333, 32'h00C200C0);
    check("wconf_port_a", {en_a, we_a, addr_a, din_a}, {2'b11, 8'h33, 8'hC0});
    check("wconf_en_b", en_b, 0);
    settle(4'b0001);
    check("conflict_cnt1", conflict_cnt, 1);
    cyc(4'b0100, 4'b0100, 32'h33333333, 32'h00C200C0, 4'b0100);
    check("conflict_hold", conflict_cnt, 1);
    cyc(4'b0001, 4'b0001, 32'h00000007, 32'h000000A5, 4'b0001);
    cyc(4'b0001, 4'b0000, 32'h00000007, 0, 4'b0001);
    check("raw_a5", bus.rdata[7:0], 8'hA5);
    cyc(4'b0001, 4'b0000, 32'h00000033, 0, 4'b0001);
    check("portb_write_c2", bus.rdata[7:0], 8'hC2);
    cyc(4'b1000, 4'h0, BASE, 0, 4'b1000);
    for (int k = 0; k < 4; k++) cyc(4'hF, 4'h0, BASE, 0, (k % 2 == 1) ? 4'b1100 : 4'b0011);
    cyc(4'b0011, 4'h0, 32'h55555555, 0, 4'b0011);
    cyc(4'b1000, 4'h0, BASE, 0, 4'b1000);
    drive(4'b0011, 4'b0010, 32'h66666666, 32'h00007700);
    check("rwconf_en_b", en_b, 0);
    settle(4'b0001);
    check("conflict_cnt2", conflict_cnt, 2);
    cyc(4'b0010, 4'b0010, 32'h66666666, 32'h00007700, 4'b0010);
    cyc(4'b0001, 4'b0000, 32'h66666666, 0, 4'b0001);
    check("rw_77", bus.rdata[7:0], 8'h77);
    drive(4'b1001, 4'h0, BASE, 0);
    check("wrap_addr_a", addr_a, 8'h40);
    check("wrap_addr_b", {en_b, addr_b}, {1'b1, 8'h10});
    settle(4'b1001);
    drive(4'b0010, 4'h0, BASE, 0);
    check("pre_reset_gnt", bus.gnt, 4'b0010);
    #1 reset = 1'b0;
    #1 bus.req = 4'hF;
    check_idle("mid_reset");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_idle("held_reset");
      check("held_reset_cnt", conflict_cnt, 0);
    end
    reset = 1'b1;
    bus.req = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("post_reset_rvalid", bus.rvalid, 0);
    end
    drive(4'hF, 4'h0, BASE, 0);
    check("post_reset_addr_a", addr_a, 8'h10);
    settle(4'b0011);
    bus.req = 4'h0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dpr_port_arbiter.md
DPR_PORT_ARBITER -- requirements
Module: dpr_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter ADDR_SIZE, default 8: RAM address width.
REQ-003 SHALL have parameter DATA_SIZE, default 8: RAM data width.
REQ-004 SHALL have port clk, in, 1: the one clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, in, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req, in, NUM_REQ: per-requester access request.
REQ-007 SHALL have port we, in, NUM_REQ: per-requester write (1) or read (0).
REQ-008 SHALL have port addr, in, NUM_REQ*ADDR_SIZE: packed addresses; requester i owns slice i.
REQ-009 SHALL have port wdata, in, NUM_REQ*DATA_SIZE: packed write data.
REQ-010 SHALL have port gnt, out, NUM_REQ: combinational same-cycle grant.
REQ-011 SHALL have port rvalid, out, NUM_REQ: read data valid.
REQ-012 SHALL have port rdata, out, NUM_REQ*DATA_SIZE: packed read data.
REQ-013 SHALL have ports en_a/we_a/addr_a/din_a, out, 1/1/ADDR_SIZE/DATA_SIZE: RAM port A controls; en_b/we_b/addr_b/din_b are the same for port B.
REQ-014 SHALL have ports dout_a and dout_b, in, DATA_SIZE: RAM read data, registered inside the RAM with 1-cycle latency.

Function
REQ-015 SHALL make at most two grants per cycle, at most one per requester.
- First winner is the lowest index at or after rr_ptr (circular) with req=1; it drives port A.
- Second winner is the next such index after the first; it drives port B.
REQ-016 SHALL treat a request as held until gnt; a request dropped without gnt is a legal retraction and has no side effect.
REQ-017 SHALL treat addresses as conflicting when the second winner's address equals the first's and either request has we=1.
- In a conflict only the first winner is granted.
- The second winner stays pending and competes in the next cycle.
- Two reads to the same address do not conflict; both are granted.
REQ-018 SHALL drive each port with en=1 and we, addr and din copied from its winner; with no winner: en=0, we=0, addr=0, din=0.
REQ-019 SHALL update rr_ptr each cycle with any grant to (last granted index + 1) mod NUM_REQ, and SHALL hold it otherwise.
REQ-020 SHALL, for a granted read in cycle N, register the port and requester index as a tag.
- In cycle N+1, rvalid[i]=1 and rdata slice i equals the tagged port's dout.
- Write grants produce no rvalid.
REQ-021 SHALL assert rvalid for exactly one cycle per granted read; rdata slices without rvalid are 0.
REQ-022 SHALL accept a new grant to requester i in cycle N+1 while its read from cycle N returns (full throughput).
REQ-023 SHALL keep a 16-bit saturating conflict_cnt, incremented on each REQ-017 deferral, readable as output port conflict_cnt, out, 16.

Reset
REQ-024 SHALL, while reset=0, force:
- rr_ptr=0, read tags invalid, conflict_cnt=0;
- gnt=0, rvalid=0, rdata=0, en_a=0, en_b=0, we_a=0, we_b=0.
REQ-025 SHALL discard any read in flight when reset asserts mid-operation: no rvalid after release.
REQ-026 SHALL allow the first grant in the first cycle after reset deasserts, with requester 0 highest priority.

Structure
REQ-027 SHALL place the following in package dpr_arb_pkg: default parameter values, the port-select encoding (PORT_A=0, PORT_B=1), and the read-tag struct (valid, port, index).
REQ-028 SHALL implement circular find-first-set as sub-module rr_pick (inputs: request vector, start index), instantiated twice, with the first winner masked for the second pick.

Verification
REQ-029 SHALL cover: after reset, req=4'b0011, both reads to 0x10 and 0x20 -> gnt=4'b0011; port A reads 0x10, port B reads 0x20; next cycle rvalid=4'b0011 with RAM contents.
REQ-030 SHALL cover: req=4'b0101, both we=1, addr=0x33 -> gnt=4'b0001; next cycle gnt=4'b0100; conflict_cnt=1.
REQ-031 SHALL cover: req=4'b1111 held, all reads, distinct addresses, for 4 cycles -> grant pairs {0,1},{2,3},{0,1},{2,3}.
REQ-032 SHALL cover: req0 write 0xA5 to 0x07 in cycle N, read 0x07 in cycle N+1 -> rvalid0 in N+2 with rdata0=0xA5.
REQ-033 SHALL cover: reset asserted the cycle after a read grant -> no rvalid at any time, all outputs 0 while reset=0.
REQ-034 SHALL cover: req=4'b1000 only, rr_ptr=0 -> port A serves requester 3, port B idle, rr_ptr becomes 0.
